// File: rtl/uart_defines.sv
// Shared UART definitions: receive-side state encoding, oversampling
// constants and the FIFO geometry common to the transmit and receive PHYs.
package uart_defines;

    // FIFO geometry shared by both directions
    localparam int FIFO_SIZE  = 16;
    localparam int FIFO_BITS  = 4;

    // 16x oversampling; the start bit is qualified at its middle
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    localparam logic [3:0] OS_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        RX_SYNC_IDLE,
        RX_SYNC_START,
        RX_SYNC_DATA,
        RX_SYNC_STOP
    } uart_rx_sync_t;

    // Full when the wrap bits differ and the index bits match
    function automatic logic ptr_full(input logic [FIFO_BITS:0] wr,
                                      input logic [FIFO_BITS:0] rd);
        return (wr[FIFO_BITS] != rd[FIFO_BITS]) &&
               (wr[FIFO_BITS-1:0] == rd[FIFO_BITS-1:0]);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Generic metastability synchronizer: a STAGES-deep flop chain whose
// flops all reset to RESET_VAL. Reusable for any asynchronous input.
module uart_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the chain, oldest sample at the top
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_phy.sv
// UART receive PHY, 8N1, LSB first. The rx line is synchronized, sampled
// at 16x baud, the start bit is qualified at mid-bit, data and stop bits
// are sampled at the end of each 16-tick window, and good bytes land in an
// inline FIFO drained by a valid/ready consumer. Framing and overrun
// errors are sticky until err_clr.
module uart_rx_phy
    import uart_defines::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       baud_tick_16x,
    input  logic       rx,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam logic [FIFO_BITS:0] PTR_ONE = 1;

    logic                 rx_s;
    uart_rx_sync_t        state;
    logic [3:0]           os_cnt;
    logic [2:0]           bit_cnt;
    logic [7:0]           shift_reg;
    logic                 armed;

    logic [7:0]           mem [FIFO_SIZE];
    logic [FIFO_BITS:0]   rd_ptr;
    logic [FIFO_BITS:0]   wr_ptr;

    logic                 empty;
    logic                 full;
    logic                 mid_stop;
    logic                 push_req;
    logic                 stop_bad;
    logic                 pop;

    uart_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rx),
        .q    (rx_s)
    );

    // FIFO status and the single-cycle stop-bit decision strobes
    always_comb begin
        empty    = (rd_ptr == wr_ptr);
        full     = ptr_full(wr_ptr, rd_ptr);
        mid_stop = baud_tick_16x && (state == RX_SYNC_STOP) && (os_cnt == OS_LAST);
        push_req = mid_stop && rx_s;
        stop_bad = mid_stop && !rx_s;
        pop      = !empty && rx_ready;
    end

    assign rx_valid = !empty;
    assign rx_data  = mem[rd_ptr[FIFO_BITS-1:0]];

    // Frame receiver: start qualification, data shifting and stop check.
    // 'armed' keeps a held-low line (break) from retriggering a frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RX_SYNC_IDLE;
            os_cnt    <= 4'd0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'd0;
            armed     <= 1'b0;
        end else if (baud_tick_16x) begin
            case (state)
                RX_SYNC_IDLE: begin
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state  <= RX_SYNC_START;
                        os_cnt <= 4'd0;
                        armed  <= 1'b0;
                    end
                end
                RX_SYNC_START: begin
                    os_cnt <= os_cnt + 4'd1;
                    if (os_cnt == OS_MID) begin
                        if (!rx_s) begin
                            state   <= RX_SYNC_DATA;
                            os_cnt  <= 4'd0;
                            bit_cnt <= 3'd0;
                        end else begin
                            state <= RX_SYNC_IDLE;
                            armed <= 1'b1;
                        end
                    end
                end
                RX_SYNC_DATA: begin
                    os_cnt <= os_cnt + 4'd1;
                    if (os_cnt == OS_LAST) begin
                        shift_reg[bit_cnt] <= rx_s;
                        os_cnt             <= 4'd0;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_SYNC_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                RX_SYNC_STOP: begin
                    os_cnt <= os_cnt + 4'd1;
                    if (os_cnt == OS_LAST) begin
                        state  <= RX_SYNC_IDLE;
                        os_cnt <= 4'd0;
                        armed  <= rx_s;
                    end
                end
                default: begin
                    state <= RX_SYNC_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers; a push while full is dropped even if a pop happens too
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_req && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_req && !full) begin
            mem[wr_ptr[FIFO_BITS-1:0]] <= shift_reg;
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (stop_bad) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (push_req && full) begin
                overrun_err <= 1'b1;
            end else if (err_clr) begin
                overrun_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_phy.sv
// Testbench for uart_rx_phy: directed scenarios plus randomized frames,
// checked against a byte-level model (expected queue and error flags).
module tb_uart_rx_phy;
    import uart_defines::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       baud_tick_16x = 1'b1;
    logic       rx = 1'b1;
    logic       err_clr = 1'b0;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;

    logic       readyReq = 1'b0;
    logic       randReady = 1'b0;
    logic       randBit = 1'b1;

    int         checkCount = 0;
    int         passCount = 0;
    bit         cmpOn = 1'b0;
    bit         settled = 1'b1;

    logic [7:0] modelQ[$];
    logic       modelFe = 1'b0;
    logic       modelOe = 1'b0;
    logic [7:0] popped[$];

    assign rx_ready = randReady ? randBit : readyReq;

    uart_rx_phy #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .baud_tick_16x (baud_tick_16x),
        .rx            (rx),
        .rx_ready      (rx_ready),
        .err_clr       (err_clr),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .frame_err     (frame_err),
        .overrun_err   (overrun_err)
    );

    // Free-running clock
    initial forever #5 clk = ~clk;

    // Random consumer readiness, used only during the randomized phase
    always @(posedge clk) randBit <= ($urandom_range(0, 3) != 0);

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic driveBit(input logic lvl, input int n);
        rx = lvl;
        waitCycles(n);
    endtask

    // One 8N1 frame at 16 clk per bit. The model takes the byte (or the
    // error) when the stop bit starts; outputs are unchecked during the stop bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stopLvl, input bit checkLatency);
        driveBit(1'b0, 16);
        for (int i = 0; i < 8; i++) driveBit(data[i], 16);
        settled = 1'b0;
        rx = stopLvl;
        if (stopLvl) begin
            if (modelQ.size() >= FIFO_SIZE) modelOe = 1'b1;
            else modelQ.push_back(data);
        end else begin
            modelFe = 1'b1;
        end
        if (checkLatency) begin
            waitCycles(4);
            checkOutput("valid_before_mid_stop", {7'd0, rx_valid}, 8'd0);
            waitCycles(11);
            checkOutput("valid_after_mid_stop", {7'd0, rx_valid}, 8'd1);
            waitCycles(1);
        end else begin
            waitCycles(16);
        end
        settled = 1'b1;
    endtask

    task automatic pulseErrClr();
        err_clr = 1'b1;
        waitCycles(1);
        err_clr = 1'b0;
        modelFe = 1'b0;
        modelOe = 1'b0;
    endtask

    task automatic drainFifo();
        readyReq = 1'b1;
        for (int i = 0; i < FIFO_SIZE + 8; i++) begin
            if (!rx_valid) break;
            waitCycles(1);
        end
        checkOutput("drain_done", {7'd0, rx_valid}, 8'd0);
        readyReq = 1'b0;
    endtask

    // Compare DUT against the model on every settled cycle, and follow pops
    always @(negedge clk) begin
        if (rstn && cmpOn) begin
            if (settled) begin
                checkOutput("rx_valid", {7'd0, rx_valid}, {7'd0, modelQ.size() != 0});
                if (modelQ.size() != 0) checkOutput("rx_data", rx_data, modelQ[0]);
                checkOutput("frame_err", {7'd0, frame_err}, {7'd0, modelFe});
                checkOutput("overrun_err", {7'd0, overrun_err}, {7'd0, modelOe});
            end
            if (rx_valid && rx_ready) begin
                if (modelQ.size() == 0) begin
                    checkOutput("pop_with_model_empty", {7'd0, rx_valid}, 8'd0);
                end else begin
                    if (!settled) checkOutput("pop_data", rx_data, modelQ[0]);
                    void'(modelQ.pop_front());
                end
            end
        end
    end

    // Record every accepted byte for the directed order checks
    always @(negedge clk) begin
        if (rstn && rx_valid && rx_ready) popped.push_back(rx_data);
    end

    // Watchdog so the run always ends
    initial begin
        #3000000;
        checkCount++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        logic [7:0] b81;
        int         gap;
        int         len;
        logic [7:0] d;
        logic       stopLvl;

        // Reset values
        waitCycles(3);
        checkOutput("reset_valid", {7'd0, rx_valid}, 8'd0);
        checkOutput("reset_frame_err", {7'd0, frame_err}, 8'd0);
        checkOutput("reset_overrun_err", {7'd0, overrun_err}, 8'd0);
        rstn = 1'b1;
        cmpOn = 1'b1;
        waitCycles(32);

        // Single byte held in the FIFO
        $display("[TB] single byte");
        applyStimulus(8'hA5, 1'b1, 1'b1);
        checkOutput("single_valid", {7'd0, rx_valid}, 8'd1);
        checkOutput("single_data", rx_data, 8'hA5);
        checkOutput("single_frame_err", {7'd0, frame_err}, 8'd0);
        checkOutput("single_overrun_err", {7'd0, overrun_err}, 8'd0);
        popped.delete();
        drainFifo();
        checkOutput("single_pop_count", 8'(popped.size()), 8'd1);
        if (popped.size() > 0) checkOutput("single_pop_data", popped[0], 8'hA5);
        waitCycles(16);

        // False start: short low glitch
        $display("[TB] false start");
        driveBit(1'b0, 5);
        driveBit(1'b1, 40);
        checkOutput("glitch_valid", {7'd0, rx_valid}, 8'd0);
        checkOutput("glitch_frame_err", {7'd0, frame_err}, 8'd0);

        // Framing error, clear, then a good byte
        $display("[TB] framing error");
        applyStimulus(8'h3C, 1'b0, 1'b0);
        driveBit(1'b1, 32);
        checkOutput("fe_set", {7'd0, frame_err}, 8'd1);
        checkOutput("fe_fifo_empty", {7'd0, rx_valid}, 8'd0);
        pulseErrClr();
        checkOutput("fe_cleared", {7'd0, frame_err}, 8'd0);
        applyStimulus(8'h11, 1'b1, 1'b0);
        checkOutput("after_fe_data", rx_data, 8'h11);
        popped.delete();
        drainFifo();
        checkOutput("after_fe_pop_count", 8'(popped.size()), 8'd1);

        // Fill and overrun
        $display("[TB] fifo fill and overrun");
        for (int i = 0; i <= FIFO_SIZE; i++) applyStimulus(8'(i), 1'b1, 1'b0);
        checkOutput("overrun_set", {7'd0, overrun_err}, 8'd1);
        checkOutput("overrun_head", rx_data, 8'h00);
        popped.delete();
        drainFifo();
        checkOutput("overrun_pop_count", 8'(popped.size()), 8'(FIFO_SIZE));
        for (int i = 0; i < popped.size(); i++) checkOutput("overrun_order", popped[i], 8'(i));
        pulseErrClr();
        checkOutput("overrun_cleared", {7'd0, overrun_err}, 8'd0);

        // Back-to-back frames with the consumer always ready
        $display("[TB] back-to-back");
        popped.delete();
        readyReq = 1'b1;
        applyStimulus(8'h55, 1'b1, 1'b0);
        applyStimulus(8'hAA, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        driveBit(1'b1, 32);
        readyReq = 1'b0;
        checkOutput("b2b_pulse_count", 8'(popped.size()), 8'd3);
        if (popped.size() == 3) begin
            checkOutput("b2b_data0", popped[0], 8'h55);
            checkOutput("b2b_data1", popped[1], 8'hAA);
            checkOutput("b2b_data2", popped[2], 8'hFF);
        end

        // Reset in the middle of a frame
        $display("[TB] reset mid-frame");
        applyStimulus(8'h77, 1'b1, 1'b0);
        b81 = 8'h81;
        driveBit(1'b0, 16);
        for (int i = 0; i < 4; i++) driveBit(b81[i], 16);
        driveBit(b81[4], 8);
        rstn = 1'b0;
        modelQ.delete();
        modelFe = 1'b0;
        modelOe = 1'b0;
        rx = 1'b1;
        #1;
        checkOutput("midreset_valid", {7'd0, rx_valid}, 8'd0);
        checkOutput("midreset_frame_err", {7'd0, frame_err}, 8'd0);
        waitCycles(4);
        rstn = 1'b1;
        waitCycles(32);
        popped.delete();
        readyReq = 1'b1;
        applyStimulus(8'h42, 1'b1, 1'b0);
        driveBit(1'b1, 16);
        readyReq = 1'b0;
        checkOutput("midreset_pop_count", 8'(popped.size()), 8'd1);
        if (popped.size() > 0) checkOutput("midreset_pop_data", popped[0], 8'h42);

        // Randomized frames, gaps, glitches, error clears and readiness
        $display("[TB] random frames");
        randReady = 1'b1;
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom_range(0, 255));
            stopLvl = ($urandom_range(0, 7) != 0);
            applyStimulus(d, stopLvl, 1'b0);
            gap = $urandom_range(0, 2);
            if (!stopLvl && gap == 0) gap = 1;
            if (gap > 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 6);
                    driveBit(1'b0, len);
                    driveBit(1'b1, gap * 16 - len);
                end else begin
                    rx = 1'b1;
                    if ($urandom_range(0, 3) == 0) begin
                        pulseErrClr();
                        driveBit(1'b1, gap * 16 - 1);
                    end else begin
                        driveBit(1'b1, gap * 16);
                    end
                end
            end
        end
        rx = 1'b1;
        randReady = 1'b0;
        waitCycles(32);
        drainFifo();
        waitCycles(4);

        cmpOn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/uart_rx_phy.md
Name: uart_rx_phy

Overview:
UART receive physical layer, the receive-side counterpart of uart_tx_phy, for 8N1 framing, LSB first. It oversamples the serial `rx` line at 16x baud, qualifies the start bit at mid-bit, and shifts in 8 data bits. It checks the stop bit and pushes good bytes into a FIFO. The downstream consumer (UART MMIO/bus bridge) pops bytes with a valid/ready handshake; framing and overrun errors are reported as sticky flags.

Parameters:
SYNC_STAGES, 2, depth of the metastability synchronizer on `rx` (minimum 2).

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
baud_tick_16x  input  1  one-clk pulse at 16x baud rate, from the shared baud generator
rx  input  1  asynchronous serial input; idle high
rx_ready  input  1  consumer accepts the head byte this cycle
err_clr  input  1  clears both sticky error flags
rx_data  output  8  FIFO head byte; valid only while rx_valid=1
rx_valid  output  1  FIFO non-empty
frame_err  output  1  sticky: a stop bit was sampled as 0
overrun_err  output  1  sticky: a good byte was dropped because the FIFO was full

Behaviour:
- Reset is asynchronous and active-low; the clock is clk.
  - Synchronizer flops reset to 1 (line idle).
  - State resets to RX_SYNC_IDLE.
  - os_cnt, bit_cnt, shift_reg, rd_ptr and wr_ptr reset to 0.
  - frame_err and overrun_err reset to 0.
  - rx_valid=0 immediately; rx_data is don't-care.
  - A reset asserted mid-frame aborts the frame; the partial byte is never pushed.
- rx_s is the SYNC_STAGES-deep synchronized `rx`; all decisions use rx_s only.
- FIFO:
  - Depth FIFO_SIZE; pointers are FIFO_BITS+1 wide, with the MSB as the wrap bit.
  - empty when rd_ptr==wr_ptr.
  - full when the MSBs differ and the low bits are equal.
  - rx_valid = !empty; rx_data = mem[rd_ptr low bits], read combinationally.
  - Pop: on rx_valid && rx_ready, rd_ptr increments.
  - Push: wr_ptr increments. Full/empty use registered pointers.
  - Push and pop in the same cycle when not full: both take effect.
  - Push attempted while full: the byte is dropped and overrun_err is set, even if a pop occurs in the same cycle.
- State machine: uart_rx_sync_t. All states advance only on baud_tick_16x.
  - RX_SYNC_IDLE:
    - On a tick with rx_s==0, go to RX_SYNC_START with os_cnt=0.
  - RX_SYNC_START:
    - Each tick increments os_cnt.
    - At the tick where os_cnt==7 (mid start bit):
      - rx_s==0: go to RX_SYNC_DATA with os_cnt=0, bit_cnt=0.
      - rx_s==1: false start; return to RX_SYNC_IDLE with no side effects.
  - RX_SYNC_DATA:
    - Each tick increments os_cnt.
    - At os_cnt==15: set shift_reg[bit_cnt] <= rx_s and os_cnt <= 0.
    - If bit_cnt==7, go to RX_SYNC_STOP; otherwise bit_cnt increments.
  - RX_SYNC_STOP:
    - At os_cnt==15 (mid stop bit):
      - rx_s==1: push shift_reg (or overrun as above).
      - rx_s==0: set frame_err and discard the byte.
    - Return to RX_SYNC_IDLE in both cases; the next start edge is detectable on the next tick.
- Latency: the pushing clk edge is the tick at mid stop bit. rx_valid rises on the following cycle.
- err_clr clears both flags. If a new error event occurs in the same cycle, the set wins.
- Break condition (line held low): each frame sets frame_err. The machine waits in IDLE until rx_s returns high and then low again; it must not re-trigger on a level low. IDLE therefore arms only after seeing rx_s==1 on a tick (1-bit `armed` flop).
- os_cnt is 4 bits and bit_cnt is 3 bits; both wrap naturally, and no other arithmetic is used.

Decomposition:
- uart_defines gains:
  - uart_rx_sync_t {RX_SYNC_IDLE, RX_SYNC_START, RX_SYNC_DATA, RX_SYNC_STOP}
  - OVERSAMPLE=16
  - MID_SAMPLE=7
- uart_defines keeps sharing FIFO_SIZE and FIFO_BITS.
- One natural sub-module: uart_sync, an SYNC_STAGES-deep flop chain with a reset value parameter. It is reusable for other async inputs.
- The FIFO stays inline, mirroring the transmit side.

Test Plan:
- Single byte: baud_tick_16x every clk; drive 0xA5 8N1 (16 clk/bit) with rx_ready=0 -> rx_valid=1, rx_data=0xA5, both errors 0.
- False start: 5-clk low glitch on idle rx -> no push, state back to IDLE, rx_valid=0.
- Framing error: 0x3C with stop bit=0 -> frame_err=1, FIFO empty. Then pulse err_clr -> frame_err=0. A following valid 0x11 is received correctly.
- FIFO fill and overrun: send FIFO_SIZE+1 bytes 0x00..0x10 with rx_ready=0 -> FIFO_SIZE entries held, overrun_err=1. Popping returns 0x00 onward in order, and the last byte is absent.
- Back-to-back with pops: three frames with no idle gap, rx_ready=1 -> three single-cycle rx_valid pulses with data 0x55, 0xAA, 0xFF. No errors; pointers wrap correctly.
- Reset mid-frame: assert rstn=0 during bit 4 of 0x81 -> outputs clear immediately. After release, idle then 0x42 -> only 0x42 is received.
